instr_encoder: RTL and testbench

- Encoder counterpart to the processor's opcode decoder. Accepts decoded instruction fields (opcode, registers, immediate, jump target) over a valid/ready handshake.
- Packs each accepted field set into a 32-bit instruction word and writes it sequentially into instruction memory through a write port.
- Used by the program loader and testbenches to build programs, so encoding matches what the control unit decodes.

---
 rtl/instr_encoder.sv | 98 +++++++++
 tb/tb_instr_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit words and writes them sequentially to instruction memory
module instr_encoder #(
   parameter int OP_CODE_BITS = 6,
   parameter int ADDR_BITS    = 8,
   parameter int DEPTH        = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 finish,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OP_CODE_BITS-1:0] opcode,
   input  logic [4:0]           rs,
   input  logic [4:0]           rt,
   input  logic [4:0]           rd,
   input  logic [15:0]          imm,
   input  logic [25:0]          target,
   output logic                 wr_en,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic [31:0]          wr_data,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS:0]   word_count,
   output logic                 illegal,
   output logic                 overflow
);
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
   localparam logic [ADDR_BITS:0] FULL = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0] ONE  = (ADDR_BITS+1)'(1);
   state_t               state_q;
   logic [ADDR_BITS:0]   addr_q;
   logic [ADDR_BITS-1:0] wr_addr_q;
   logic [31:0]          wr_data_q;
   logic [31:0]          enc_d;
   logic [3:0]           lo;
   logic                 wr_en_q, busy_q, done_q, illegal_q, overflow_q;
   logic                 legal, is_i, xfer;
   assign in_ready   = (state_q == LOAD) && (addr_q < FULL);
   assign xfer       = in_valid && in_ready;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign word_count = addr_q;
   assign illegal    = illegal_q;
   assign overflow   = overflow_q;
   // pack the fields by instruction class; fields a class does not use stay zero
   always_comb begin
      lo    = opcode[3:0];
      legal = ~|opcode[OP_CODE_BITS-1:4];
      is_i  = (lo == 4'd1) || (lo == 4'd3) || ((lo >= 4'd10) && (lo <= 4'd14));
      enc_d = {opcode, (lo == 4'd15) ? target :
                       (lo == 4'd9)  ? {rs, rt, 16'h0000} :
                       is_i          ? {rs, rt, imm} :
                                       {rs, rt, rd, 11'h000}};
   end
   // load sequencer with the one-cycle write stage and sticky error flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_en_q <= xfer && legal;
         done_q  <= state_q == DRAIN;
         if (xfer && legal) begin
            wr_addr_q <= addr_q[ADDR_BITS-1:0];
            wr_data_q <= enc_d;
            addr_q    <= addr_q + ONE;
         end
         if (xfer && !legal) illegal_q <= 1'b1;
         if ((state_q == LOAD) && in_valid && (addr_q == FULL)) overflow_q <= 1'b1;
         case (state_q)
            IDLE: if (start) begin
               state_q    <= LOAD;
               busy_q     <= 1'b1;
               addr_q     <= '0;
               illegal_q  <= 1'b0;
               overflow_q <= 1'b0;
            end
            LOAD:  if (finish) state_q <= DRAIN;
            DRAIN: state_q <= DONE;
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed loads against two encoders (full size and a 4-word one) with a write scoreboard
module tb_instr_encoder;
   typedef struct {int cyc; logic [7:0] addr; logic [31:0] data;} exp_t;
   logic        clk = 1'b0, reset = 1'b1;
   logic        start_b = 1'b0, finish_b = 1'b0, start_s = 1'b0, finish_s = 1'b0;
   logic        in_valid = 1'b0;
   logic [5:0]  opcode = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0;
   logic [15:0] imm = '0;
   logic [25:0] target = '0;
   logic        in_ready_b, wr_en_b, busy_b, done_b, illegal_b, overflow_b;
   logic [7:0]  wr_addr_b;
   logic [31:0] wr_data_b;
   logic [8:0]  wc_b;
   logic        in_ready_s, wr_en_s, busy_s, done_s, illegal_s, overflow_s;
   logic [1:0]  wr_addr_s;
   logic [31:0] wr_data_s;
   logic [2:0]  wc_s;
   int          comps = 0, fails = 0, cyc = 0, exp_addr = 0;
   bit          sel = 1'b0;
   exp_t        q_b[$], q_s[$];
   exp_t        eb, es;

   instr_encoder u_big (
      .clk(clk), .reset(reset), .start(start_b), .finish(finish_b),
      .in_valid(in_valid), .in_ready(in_ready_b), .opcode(opcode),
      .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .busy(busy_b), .done(done_b), .word_count(wc_b),
      .illegal(illegal_b), .overflow(overflow_b)
   );

   instr_encoder #(.OP_CODE_BITS(6), .ADDR_BITS(2), .DEPTH(4)) u_small (
      .clk(clk), .reset(reset), .start(start_s), .finish(finish_s),
      .in_valid(in_valid), .in_ready(in_ready_s), .opcode(opcode),
      .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
      .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
      .busy(busy_s), .done(done_s), .word_count(wc_s),
      .illegal(illegal_s), .overflow(overflow_s)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      comps++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // write monitors: every strobe must match the next expected write, including its cycle
   always @(negedge clk) begin
      if (wr_en_b) begin
         if (q_b.size() == 0) begin
            comps++;
            fails++;
            $display("FAIL wr_b unexpected: addr %h data %h", wr_addr_b, wr_data_b);
         end else begin
            eb = q_b.pop_front();
            chk("wr_b cycle", 32'(cyc), 32'(eb.cyc));
            chk("wr_b addr", {24'h0, wr_addr_b}, {24'h0, eb.addr});
            chk("wr_b data", wr_data_b, eb.data);
         end
      end
      if (wr_en_s) begin
         if (q_s.size() == 0) begin
            comps++;
            fails++;
            $display("FAIL wr_s unexpected: addr %h data %h", wr_addr_s, wr_data_s);
         end else begin
            es = q_s.pop_front();
            chk("wr_s cycle", 32'(cyc), 32'(es.cyc));
            chk("wr_s addr", {30'h0, wr_addr_s}, {24'h0, es.addr});
            chk("wr_s data", wr_data_s, es.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      if (sel) start_s = 1'b1; else start_b = 1'b1;
      tick();
      start_s  = 1'b0;
      start_b  = 1'b0;
      exp_addr = 0;
   endtask

   task automatic send(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg,
                       input bit wr, input logic [31:0] w);
      bit ok = 1'b0;
      opcode = op; rs = s; rt = t; rd = d; imm = im; target = tg;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (sel ? in_ready_s : in_ready_b) begin
            if (wr) begin
               if (sel) q_s.push_back('{cyc + 1, 8'(exp_addr), w});
               else     q_b.push_back('{cyc + 1, 8'(exp_addr), w});
               exp_addr++;
            end
            ok = 1'b1;
         end
         tick();
      end
      in_valid = 1'b0;
      if (!ok) begin
         comps++;
         fails++;
         $display("FAIL send timeout: in_ready never high for opcode %0d", op);
      end
   endtask

   task automatic finish_load(input int wc);
      bit seen = 1'b0;
      if (sel) finish_s = 1'b1; else finish_b = 1'b1;
      tick();
      finish_s = 1'b0;
      finish_b = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         if (sel ? done_s : done_b) seen = 1'b1;
         else tick();
      end
      chk("done pulse", {31'h0, seen}, 32'h1);
      chk("word_count", sel ? {29'h0, wc_s} : {23'h0, wc_b}, 32'(wc));
      tick();
      chk("done low after pulse", {31'h0, sel ? done_s : done_b}, 32'h0);
      chk("busy low in idle", {31'h0, sel ? busy_s : busy_b}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", {31'h0, in_ready_b}, 32'h0);
      chk("reset wr_en", {31'h0, wr_en_b}, 32'h0);
      chk("reset busy/done/flags", {28'h0, busy_b, done_b, illegal_b, overflow_b}, 32'h0);
      chk("reset word_count", {23'h0, wc_b}, 32'h0);
      reset = 1'b0;
      tick();
      // three-word load: add, addi, jump
      sel = 1'b0;
      do_start();
      chk("busy in load", {31'h0, busy_b}, 32'h1);
      send(6'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h00221800);
      send(6'd1, 5'd4, 5'd5, 5'd0, 16'h00FF, 26'h0, 1'b1, 32'h048500FF);
      send(6'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000100, 1'b1, 32'h3C000100);
      finish_load(3);
      // four back-to-back transfers, two idle cycles, one more
      do_start();
      for (int i = 0; i < 4; i++)
         send(6'd1, 5'd0, 5'd1, 5'd0, 16'h0010 + 16'(i), 26'h0, 1'b1, 32'h04010010 + 32'(i));
      repeat (2) tick();
      send(6'd1, 5'd0, 5'd1, 5'd0, 16'h0014, 26'h0, 1'b1, 32'h04010014);
      finish_load(5);
      // illegal opcode is consumed without a write
      do_start();
      send(6'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h08221800);
      chk("illegal before", {31'h0, illegal_b}, 32'h0);
      send(6'd20, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 32'h0);
      chk("illegal set", {31'h0, illegal_b}, 32'h1);
      send(6'd6, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0, 1'b1, 32'h18642800);
      finish_load(2);
      chk("illegal sticky", {31'h0, illegal_b}, 32'h1);
      // field masking; start also clears the sticky illegal flag
      do_start();
      chk("illegal cleared by start", {31'h0, illegal_b}, 32'h0);
      send(6'd9, 5'd7, 5'd8, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h24E80000);
      send(6'd13, 5'd2, 5'd3, 5'd31, 16'h0010, 26'h3FFFFFF, 1'b1, 32'h34430010);
      finish_load(2);
      // four-word memory: fill it, then offer a fifth word
      sel = 1'b1;
      do_start();
      for (int i = 0; i < 4; i++)
         send(6'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'(i + 1), 1'b1, 32'h3C000001 + 32'(i));
      chk("full in_ready", {31'h0, in_ready_s}, 32'h0);
      chk("overflow before", {31'h0, overflow_s}, 32'h0);
      opcode = 6'd15; target = 26'h5;
      in_valid = 1'b1;
      tick();
      chk("overflow set", {31'h0, overflow_s}, 32'h1);
      tick();
      in_valid = 1'b0;
      chk("full word_count", {29'h0, wc_s}, 32'h4);
      finish_load(4);
      chk("overflow sticky", {31'h0, overflow_s}, 32'h1);
      chk("big overflow untouched", {31'h0, overflow_b}, 32'h0);
      // reset while a write is pending
      sel = 1'b0;
      do_start();
      send(6'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h00221800);
      chk("pending write", {31'h0, wr_en_b}, 32'h1);
      reset = 1'b1;
      q_b.delete();
      #1;
      chk("abort wr_en", {31'h0, wr_en_b}, 32'h0);
      chk("abort wr_data", wr_data_b, 32'h0);
      chk("abort addr/count", {15'h0, wr_addr_b, wc_b}, 32'h0);
      chk("abort flags", {27'h0, in_ready_b, busy_b, done_b, illegal_b, overflow_b}, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      do_start();
      send(6'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1'b1, 32'h3FFFFFFF);
      finish_load(1);
      repeat (2) tick();
      chk("big scoreboard drained", 32'(q_b.size()), 32'h0);
      chk("small scoreboard drained", 32'(q_s.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
      $finish;
   end
endmodule
